// File: rtl/cfg_regs_pkg.sv
// Purpose: shared FSM encoding and address-index constants for the config register slave.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cfg_regs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_ACK  = 2'd1,
    RD_DATA = 2'd2
  } state_t;

  // Word indices (address bits [11:2]) of the fixed read-only locations.
  localparam logic [9:0]  STATUS_IDX    = 10'h3FF;
  localparam logic [9:0]  WRCNT_IDX     = 10'h3FE;
  localparam logic [31:0] UNMAPPED_DATA = 32'hFFFFFFFF;

endpackage

// File: rtl/cfg_reg_strb_merge.sv
// Purpose: byte-lane merge of a register's old value with new write data under a strobe.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module cfg_reg_strb_merge
  import cfg_regs_pkg::*;
#(
  parameter int pDATA_WIDTH = 32
) (
  input  logic [pDATA_WIDTH-1:0]   old_data,
  input  logic [pDATA_WIDTH-1:0]   new_data,
  input  logic [pDATA_WIDTH/8-1:0] strb,
  output logic [pDATA_WIDTH-1:0]   merged
);

  // Take each byte from the new data only where its strobe bit is set.
  always_comb begin
    merged = old_data;
    for (int k = 0; k < pDATA_WIDTH/8; k++) begin
      if (strb[k]) merged[8*k +: 8] = new_data[8*k +: 8];
    end
  end

endmodule

// File: rtl/cfg_axil_reg_slave.sv
// Purpose: AXI-Lite register bank (pNUM_REGS R/W words + status at 0xFFC); optional write counter via CFG_REGS_WR_CNT_EN.
// Latency: write acked 1 cycle after AW+W seen, read data 1 cycle after AR seen; 2 cycles minimum per access.
// Backpressure: AW without W waits unacked; read data held until rready, abandoned if cc_enable drops.
module cfg_axil_reg_slave
  import cfg_regs_pkg::*;
#(
  parameter int pADDR_WIDTH = 15,
  parameter int pDATA_WIDTH = 32,
  parameter int pNUM_REGS   = 8
) (
  input  logic                           axi_clk,
  input  logic                           axi_rst,
  input  logic                           cc_enable,
  input  logic                           axi_awvalid,
  input  logic [pADDR_WIDTH-1:0]         axi_awaddr,
  input  logic                           axi_wvalid,
  input  logic [pDATA_WIDTH-1:0]         axi_wdata,
  input  logic [pDATA_WIDTH/8-1:0]       axi_wstrb,
  output logic                           axi_awready,
  output logic                           axi_wready,
  input  logic                           axi_arvalid,
  input  logic [pADDR_WIDTH-1:0]         axi_araddr,
  output logic                           axi_arready,
  output logic                           axi_rvalid,
  output logic [pDATA_WIDTH-1:0]         axi_rdata,
  input  logic                           axi_rready,
  input  logic [pDATA_WIDTH-1:0]         status_in,
  output logic [pNUM_REGS*pDATA_WIDTH-1:0] reg_out,
  output logic [pNUM_REGS-1:0]           wr_pulse
);

  state_t                   state;
  logic [9:0]               idx;
  logic [pDATA_WIDTH-1:0]   wdata_q;
  logic [pDATA_WIDTH/8-1:0] wstrb_q;
  logic [pDATA_WIDTH-1:0]   regs   [pNUM_REGS];
  logic [pDATA_WIDTH-1:0]   merged [pNUM_REGS];
  logic [pDATA_WIDTH-1:0]   rd_mux;
  logic [9:0]               aw_idx;
  logic [9:0]               ar_idx;
  logic                     unused_addr_bits;

  // Only the word offset inside the 4 KB window is decoded.
  assign aw_idx = axi_awaddr[11:2];
  assign ar_idx = axi_araddr[11:2];
  assign unused_addr_bits = ^{axi_awaddr[pADDR_WIDTH-1:12], axi_awaddr[1:0],
                              axi_araddr[pADDR_WIDTH-1:12], axi_araddr[1:0]};

  // Handshake outputs are pure decodes of the registered state.
  assign axi_awready = (state == WR_ACK);
  assign axi_wready  = (state == WR_ACK);
  assign axi_arready = (state == RD_DATA);
  assign axi_rvalid  = (state == RD_DATA);

`ifdef CFG_REGS_WR_CNT_EN
  logic [15:0] wr_cnt;

  // Saturating count of committed in-range writes; a write to its own offset clears it.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      wr_cnt <= '0;
    end else if (state == WR_ACK) begin
      if (idx == WRCNT_IDX)
        wr_cnt <= '0;
      else if (32'(idx) < 32'(pNUM_REGS) && wr_cnt != 16'hFFFF)
        wr_cnt <= wr_cnt + 16'd1;
    end
  end
`endif

  // Read data source for the address currently presented on AR.
  always_comb begin
    rd_mux = UNMAPPED_DATA;
    if (ar_idx == STATUS_IDX) begin
      rd_mux = status_in;
    end else if (ar_idx == WRCNT_IDX) begin
`ifdef CFG_REGS_WR_CNT_EN
      rd_mux = {16'h0, wr_cnt};
`else
      rd_mux = UNMAPPED_DATA;
`endif
    end
    for (int i = 0; i < pNUM_REGS; i++) begin
      if (ar_idx == 10'(i)) rd_mux = regs[i];
    end
  end

  // Access FSM: writes take priority over reads arriving in the same cycle.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state     <= IDLE;
      idx       <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      axi_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cc_enable && axi_awvalid && axi_wvalid) begin
            idx     <= aw_idx;
            wdata_q <= axi_wdata;
            wstrb_q <= axi_wstrb;
            state   <= WR_ACK;
          end else if (cc_enable && axi_arvalid) begin
            idx       <= ar_idx;
            axi_rdata <= rd_mux;
            state     <= RD_DATA;
          end
        end
        WR_ACK: state <= IDLE;
        RD_DATA: begin
          if (axi_rready || !cc_enable) begin
            axi_rdata <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Commit the merged word at the end of the ack cycle; out-of-range indices match no register.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      wr_pulse <= '0;
      for (int i = 0; i < pNUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < pNUM_REGS; i++) begin
        wr_pulse[i] <= (state == WR_ACK) && (idx == 10'(i));
        if ((state == WR_ACK) && (idx == 10'(i))) regs[i] <= merged[i];
      end
    end
  end

  for (genvar g = 0; g < pNUM_REGS; g++) begin : g_reg
    assign reg_out[g*pDATA_WIDTH +: pDATA_WIDTH] = regs[g];

    cfg_reg_strb_merge #(
      .pDATA_WIDTH (pDATA_WIDTH)
    ) u_merge (
      .old_data (regs[g]),
      .new_data (wdata_q),
      .strb     (wstrb_q),
      .merged   (merged[g])
    );
  end

endmodule

// File: tb/tb_cfg_axil_reg_slave.sv
// Purpose: directed bench for cfg_axil_reg_slave with a transaction-level register model.
// Latency: model expectations are placed on the cycles where acks and data must appear.
// Backpressure: exercises held rready, cc_enable drop and half-presented writes.
module tb_cfg_axil_reg_slave;

  localparam int N = 8;

  logic          axi_clk = 1'b0;
  logic          axi_rst;
  logic          cc_enable;
  logic          axi_awvalid;
  logic [14:0]   axi_awaddr;
  logic          axi_wvalid;
  logic [31:0]   axi_wdata;
  logic [3:0]    axi_wstrb;
  logic          axi_awready;
  logic          axi_wready;
  logic          axi_arvalid;
  logic [14:0]   axi_araddr;
  logic          axi_arready;
  logic          axi_rvalid;
  logic [31:0]   axi_rdata;
  logic          axi_rready;
  logic [31:0]   status_in;
  logic [N*32-1:0] reg_out;
  logic [N-1:0]  wr_pulse;

  always #5 axi_clk = ~axi_clk;

  cfg_axil_reg_slave #(
    .pADDR_WIDTH (15),
    .pDATA_WIDTH (32),
    .pNUM_REGS   (N)
  ) dut (
    .axi_clk     (axi_clk),
    .axi_rst     (axi_rst),
    .cc_enable   (cc_enable),
    .axi_awvalid (axi_awvalid),
    .axi_awaddr  (axi_awaddr),
    .axi_wvalid  (axi_wvalid),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_awready (axi_awready),
    .axi_wready  (axi_wready),
    .axi_arvalid (axi_arvalid),
    .axi_araddr  (axi_araddr),
    .axi_arready (axi_arready),
    .axi_rvalid  (axi_rvalid),
    .axi_rdata   (axi_rdata),
    .axi_rready  (axi_rready),
    .status_in   (status_in),
    .reg_out     (reg_out),
    .wr_pulse    (wr_pulse)
  );

  // Reference model: register contents, write counter and expected port values.
  logic [31:0] m_regs [N];
  logic [15:0] m_cnt;
  logic        e_wack;
  logic        e_rvalid;
  logic [31:0] e_rdata;
  logic [N-1:0] e_pulse;
  bit          chk_en;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge axi_clk) begin
    if (chk_en) begin
      check("awready", {31'b0, axi_awready}, {31'b0, e_wack});
      check("wready",  {31'b0, axi_wready},  {31'b0, e_wack});
      check("arready", {31'b0, axi_arready}, {31'b0, e_rvalid});
      check("rvalid",  {31'b0, axi_rvalid},  {31'b0, e_rvalid});
      check("rdata",   axi_rdata, e_rdata);
      check("wr_pulse", 32'(wr_pulse), 32'(e_pulse));
      for (int i = 0; i < N; i++)
        check($sformatf("reg_out[%0d]", i), reg_out[32*i +: 32], m_regs[i]);
    end
  end

  function automatic logic [31:0] model_read(input logic [14:0] addr);
    logic [9:0] w;
    w = addr[11:2];
    if (int'(w) < N) return m_regs[w];
    if (w == 10'h3FF) return status_in;
`ifdef CFG_REGS_WR_CNT_EN
    if (w == 10'h3FE) return {16'h0, m_cnt};
`endif
    return 32'hFFFFFFFF;
  endfunction

  task automatic model_commit(input logic [14:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [9:0] w;
    w = addr[11:2];
    e_pulse = '0;
    if (int'(w) < N) begin
      for (int k = 0; k < 4; k++)
        if (strb[k]) m_regs[w][8*k +: 8] = data[8*k +: 8];
      e_pulse = N'(1) << w;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (w == 10'h3FE) begin
      m_cnt = '0;
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic do_write(input logic [14:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [N-1:0] pulse_seen);
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    axi_awaddr = addr;  axi_wdata = data; axi_wstrb = strb;
    e_wack = 1'b0;
    tick();
    e_wack = 1'b1;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    e_wack = 1'b0;
    model_commit(addr, data, strb);
    pulse_seen = wr_pulse;
    tick();
    e_pulse = '0;
  endtask

  task automatic do_read(input logic [14:0] addr, input int hold, output logic [31:0] got);
    logic [31:0] exp;
    axi_arvalid = 1'b1; axi_araddr = addr; axi_rready = (hold == 0);
    exp = model_read(addr);
    tick();
    e_rvalid = 1'b1; e_rdata = exp;
    for (int c = 0; c < hold; c++) tick();
    got = axi_rdata;
    axi_rready = 1'b1;
    tick();
    axi_arvalid = 1'b0; axi_rready = 1'b0;
    e_rvalid = 1'b0; e_rdata = '0;
  endtask

  logic [31:0]  got;
  logic [N-1:0] pls;

  initial begin
    axi_rst = 1'b1; cc_enable = 1'b0;
    axi_awvalid = 1'b0; axi_awaddr = '0; axi_wvalid = 1'b0; axi_wdata = '0; axi_wstrb = '0;
    axi_arvalid = 1'b0; axi_araddr = '0; axi_rready = 1'b0;
    status_in = 32'h5A5A0001;
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    m_cnt = '0; e_wack = 1'b0; e_rvalid = 1'b0; e_rdata = '0; e_pulse = '0;
    chk_en = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    check("reset_rvalid", {31'b0, axi_rvalid}, 32'h0);
    check("reset_reg0", reg_out[31:0], 32'h0);
    axi_rst = 1'b0;
    tick();
    cc_enable = 1'b1;

    // Full-word write to reg0.
    do_write(15'h000, 32'hDEADBEEF, 4'hF, pls);
    check("reg0_literal", reg_out[31:0], 32'hDEADBEEF);
    check("reg0_pulse", 32'(pls), 32'h1);

    // Byte-lane write to reg1.
    do_write(15'h004, 32'h11223344, 4'hF, pls);
    do_write(15'h004, 32'hAABBCCDD, 4'b0101, pls);
    check("reg1_strb_literal", reg_out[63:32], 32'h11BB33DD);
    check("reg1_pulse", 32'(pls), 32'h2);

    // Reads: register, status, unmapped.
    do_read(15'h004, 0, got); check("rd_reg1", got, 32'h11BB33DD);
    do_read(15'h0FFC, 0, got); check("rd_status", got, 32'h5A5A0001);
    do_read(15'h100, 0, got); check("rd_unmapped", got, 32'hFFFFFFFF);
    do_read(15'h7000, 0, got); check("rd_upper_bits_ignored", got, 32'hDEADBEEF);

    // Out-of-range write to the status offset: acked, nothing changes.
    do_write(15'h0FFC, 32'h12345678, 4'hF, pls);
    check("ffc_write_no_pulse", 32'(pls), 32'h0);

    // Simultaneous write and read to reg2: write first.
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_awaddr = 15'h008;
    axi_wdata = 32'h0000CAFE; axi_wstrb = 4'hF;
    axi_arvalid = 1'b1; axi_araddr = 15'h008; axi_rready = 1'b1;
    tick();
    e_wack = 1'b1;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; e_wack = 1'b0;
    model_commit(15'h008, 32'h0000CAFE, 4'hF);
    got = model_read(15'h008);
    tick();
    e_pulse = '0; e_rvalid = 1'b1; e_rdata = got;
    got = axi_rdata;
    tick();
    axi_arvalid = 1'b0; axi_rready = 1'b0; e_rvalid = 1'b0; e_rdata = '0;
    check("simul_read_after_write", got, 32'h0000CAFE);

    // Read with rready held low for three cycles.
    do_read(15'h000, 3, got); check("rd_hold_reg0", got, 32'hDEADBEEF);

    // Requests while the target is deselected are ignored.
    cc_enable = 1'b0;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_awaddr = 15'h008; axi_wdata = 32'h0BADF00D;
    axi_wstrb = 4'hF; axi_arvalid = 1'b1; axi_araddr = 15'h008;
    tick(); tick(); tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
    cc_enable = 1'b1;
    tick();
    check("disabled_no_change", reg_out[95:64], 32'h0000CAFE);

    // Half-presented writes never get acked.
    axi_awvalid = 1'b1; tick(); tick(); axi_awvalid = 1'b0;
    axi_wvalid = 1'b1; tick(); tick(); axi_wvalid = 1'b0;
    tick();

    // Read abandoned when cc_enable drops.
    axi_arvalid = 1'b1; axi_araddr = 15'h004; axi_rready = 1'b0;
    got = model_read(15'h004);
    tick();
    e_rvalid = 1'b1; e_rdata = got;
    tick();
    cc_enable = 1'b0;
    tick();
    e_rvalid = 1'b0; e_rdata = '0;
    axi_arvalid = 1'b0; cc_enable = 1'b1;
    tick();

    // Write counter window.
    do_write(15'h0FF8, 32'h0, 4'hF, pls);
    do_write(15'h00C, 32'h00000001, 4'hF, pls);
    do_write(15'h00C, 32'h00000002, 4'hF, pls);
    do_write(15'h010, 32'h00000003, 4'hF, pls);
    do_read(15'h0FF8, 0, got);
`ifdef CFG_REGS_WR_CNT_EN
    check("wrcnt_three", got, 32'h00000003);
`else
    check("wrcnt_unmapped", got, 32'hFFFFFFFF);
`endif
    do_write(15'h0FF8, 32'hFFFFFFFF, 4'hF, pls);
    do_read(15'h0FF8, 0, got);
`ifdef CFG_REGS_WR_CNT_EN
    check("wrcnt_cleared", got, 32'h00000000);
`else
    check("wrcnt_unmapped2", got, 32'hFFFFFFFF);
`endif

    // Reset in the middle of a write ack: no commit, bank cleared.
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_awaddr = 15'h014;
    axi_wdata = 32'h77777777; axi_wstrb = 4'hF;
    tick();
    e_wack = 1'b1;
    axi_rst = 1'b1;
    tick();
    axi_rst = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    e_wack = 1'b0;
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    m_cnt = '0;
    tick();
    check("post_reset_reg0", reg_out[31:0], 32'h0);
    check("post_reset_reg5", reg_out[191:160], 32'h0);
    tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cfg_axil_reg_slave.md
Name: cfg_axil_reg_slave

Overview:
AXI-Lite slave register bank sitting directly downstream of the configuration controller's AXI-Lite master port (15-bit address, no B channel).
- Occupies one 4 KB target window.
- Consumes the master's awvalid/wvalid/arvalid/rready and the per-target enable.
- Returns awready/wready/arready/rvalid/rdata.
- Drives a bank of configuration registers and per-register write strobes into the user logic.

Parameters:
- pADDR_WIDTH, 15, AXI-Lite address width from the controller.
- pDATA_WIDTH, 32, data width; only 32 is supported.
- pNUM_REGS, 8, number of R/W registers at offsets 0x000, 0x004, …; range 1..64.

Ports:
- axi_clk  in  1  sole clock.
- axi_rst  in  1  synchronous, active-high reset.
- cc_enable  in  1  target selected by the controller's address decode.
- axi_awvalid  in  1  write address valid.
- axi_awaddr  in  pADDR_WIDTH  write address; only [11:2] is used.
- axi_wvalid  in  1  write data valid.
- axi_wdata  in  32  write data.
- axi_wstrb  in  4  byte enables.
- axi_awready  out  1  write address accepted.
- axi_wready  out  1  write data accepted.
- axi_arvalid  in  1  read address valid.
- axi_araddr  in  pADDR_WIDTH  read address.
- axi_arready  out  1  read address accepted.
- axi_rvalid  out  1  read data valid.
- axi_rdata  out  32  read data.
- axi_rready  in  1  master ready for read data.
- status_in  in  32  read-only status word at offset 0xFFC.
- reg_out  out  pNUM_REGS*32  flattened register contents; reg i is at [32i+31:32i].
- wr_pulse  out  pNUM_REGS  one-cycle pulse when reg i is written.

Behaviour:
- Reset (axi_rst=1 at a clock edge):
  - State → IDLE; all registers → 0.
  - awready, wready, arready, rvalid, rdata, wr_pulse all 0.
  - Applies mid-transaction with no ack issued.
- FSM states: IDLE, WR_ACK, RD_DATA.
- IDLE:
  - If cc_enable & awvalid & wvalid: latch index = awaddr[11:2], wdata and wstrb; go to WR_ACK.
  - Else if cc_enable & arvalid: latch index = araddr[11:2]; register the read mux into rdata; go to RD_DATA.
  - A write beats a read when both are valid in the same cycle.
  - AW without W (or W without AW) waits; neither ready is asserted.
- WR_ACK (exactly 1 cycle):
  - awready = wready = 1, combinationally from state.
  - Commit at the end of the cycle if index < pNUM_REGS: byte k of reg[index] updates when wstrb[k]=1; wr_pulse[index]=1 in the following cycle.
  - Out-of-range writes, including 0xFFC, are acked and discarded.
  - Return to IDLE.
- RD_DATA:
  - arready = rvalid = 1; rdata is held stable.
  - Return to IDLE in the cycle rready=1, or immediately if cc_enable drops (no handshake completes).
  - rdata returns to 0 in IDLE.
- Read mux:
  - index < pNUM_REGS → reg[index].
  - 0xFFC → status_in, sampled at the IDLE→RD_DATA edge.
  - Anything else → 0xFFFFFFFF.
- Latency and throughput:
  - Write: ack 1 cycle after request; minimum 2 cycles per write.
  - Read: data 1 cycle after request; minimum 2 cycles per read with rready held high.
- cc_enable low in IDLE: all requests are ignored; outputs stay 0.

Optional Feature:
CFG_REGS_WR_CNT_EN
- Defined:
  - Adds a 16-bit saturating counter of committed in-range writes; it saturates at 0xFFFF.
  - Readable at offset 0xFF8 as {16'h0, cnt}.
  - Cleared by reset or by any write to 0xFF8 (the write is acked).
- Undefined: 0xFF8 behaves as unmapped and reads 0xFFFFFFFF.

Decomposition:
- Package cfg_regs_pkg holds:
  - State encoding (IDLE=2'd0, WR_ACK=2'd1, RD_DATA=2'd2).
  - Offset constants STATUS_IDX=10'h3FF and WRCNT_IDX=10'h3FE.
  - UNMAPPED_DATA=32'hFFFFFFFF.
- One sub-module, cfg_reg_strb_merge: purely combinational merge of old and new data under wstrb, instantiated per register.

Test Plan:
- Reset → all reg_out=0, wr_pulse=0, all ready/valid signals=0, rdata=0.
- cc_enable=1; write 0x000 wdata=0xDEADBEEF wstrb=4'hF → awready/wready high 1 cycle later; reg_out[31:0]=0xDEADBEEF; wr_pulse[0] pulses.
- Byte-enable write: reg1=0x11223344, then write 0x004 wdata=0xAABBCCDD wstrb=4'b0101 → reg1=0x11BB33DD.
- Read 0x004 with rready held high → rvalid 1 cycle after arvalid, rdata=0x11BB33DD; read 0xFFC with status_in=0x5A5A0001 → 0x5A5A0001; read 0x100 → 0xFFFFFFFF.
- Simultaneous aw/w/arvalid → write completes first, then the read; rready low for 3 cycles → rvalid and rdata held stable; cc_enable=0 during a request → no ready asserted, no register change.
- With CFG_REGS_WR_CNT_EN: 3 writes → 0xFF8 reads 0x00000003; write 0xFF8 → reads 0x0; without the macro, 0xFF8 reads 0xFFFFFFFF.
